// File: rtl/id_scoreboard_bypass.sv
//==============================================================================
// Module   : id_scoreboard_bypass
// Summary  : Decode-stage hazard/bypass unit. Combines a per-register
//            pending-write scoreboard with NFWD priority forward ports.
//            Optional SB_STATS_EN adds stall/hazard cycle counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_scoreboard_bypass #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int XLEN  = 32,
    parameter int NSRC  = 2,
    parameter int NFWD  = 3,
    parameter int CNT_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid_i,
    input  logic                   downstream_allowin_i,
    input  logic                   issue_we_i,
    input  logic [AW-1:0]          issue_dest_i,
    input  logic [NSRC-1:0]        src_valid_i,
    input  logic [NSRC*AW-1:0]     src_addr_i,
    input  logic [NSRC*XLEN-1:0]   rf_rdata_i,
    input  logic [NFWD-1:0]        fwd_valid_i,
    input  logic [NFWD*AW-1:0]     fwd_dest_i,
    input  logic [NFWD-1:0]        fwd_ready_i,
    input  logic [NFWD*XLEN-1:0]   fwd_data_i,
    input  logic                   retire_valid_i,
    input  logic [AW-1:0]          retire_dest_i,
    input  logic                   flush_i,
    output logic [NSRC*XLEN-1:0]   src_value_o,
    output logic                   ready_go_o,
    output logic                   issue_fire_o,
    output logic                   pending_any_o,
    output logic                   err_underflow_o
`ifdef SB_STATS_EN
    ,
    output logic [31:0]            stall_cycles_o,
    output logic [31:0]            hazard_cycles_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Entry 0 exists only for uniform indexing; it is held at zero.
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             err_q;
    logic             err_d;

    logic [NSRC-1:0]  w_src_haz;
    logic             w_dest_full;
    logic             w_inc;
    logic             w_dec;
    logic [NREG-1:0]  w_inc_oh;
    logic [NREG-1:0]  w_dec_oh;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [AW-1:0]   w_addr;
        logic            w_hit;
        logic            w_hit_rdy;
        logic [XLEN-1:0] w_hit_data;
        logic [XLEN-1:0] w_val;
        logic            w_haz;

        assign w_addr = src_addr_i[gi*AW +: AW];

        // Scan oldest to youngest so the lowest-index match wins.
        always_comb begin
            w_hit      = 1'b0;
            w_hit_rdy  = 1'b0;
            w_hit_data = '0;
            for (int j = NFWD - 1; j >= 0; j--) begin
                if (fwd_valid_i[j] && (fwd_dest_i[j*AW +: AW] == w_addr)) begin
                    w_hit      = 1'b1;
                    w_hit_rdy  = fwd_ready_i[j];
                    w_hit_data = fwd_data_i[j*XLEN +: XLEN];
                end
            end
        end

        always_comb begin
            w_val = rf_rdata_i[gi*XLEN +: XLEN];
            w_haz = 1'b0;
            if (w_addr == '0) begin
                w_val = '0;
            end else if (w_hit) begin
                w_val = w_hit_data;
                w_haz = ~w_hit_rdy;
            end else if (cnt_q[w_addr] != '0) begin
                // Writer is inside a unit that has no forward port.
                w_haz = 1'b1;
            end
        end

        assign src_value_o[gi*XLEN +: XLEN] = w_val;
        assign w_src_haz[gi]                = src_valid_i[gi] & w_haz;
    end

    assign w_dest_full  = issue_we_i && (issue_dest_i != '0) &&
                          (cnt_q[issue_dest_i] == CNT_MAX);
    assign ready_go_o   = ~(|w_src_haz) & ~w_dest_full;
    assign issue_fire_o = issue_valid_i & ready_go_o & downstream_allowin_i;

    assign w_inc = issue_fire_o & issue_we_i & (issue_dest_i != '0);
    assign w_dec = retire_valid_i & (retire_dest_i != '0);

    always_comb begin
        w_inc_oh = '0;
        w_dec_oh = '0;
        if (w_inc) w_inc_oh[issue_dest_i] = 1'b1;
        if (w_dec) w_dec_oh[retire_dest_i] = 1'b1;
    end

    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        cnt_d[0] = '0;
        if (flush_i) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_d[r] = '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_inc_oh[r] && !w_dec_oh[r]) begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end else if (w_dec_oh[r] && !w_inc_oh[r]) begin
                    if (cnt_q[r] == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] - CNT_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        pending_any_o = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            pending_any_o = pending_any_o | (|cnt_q[r]);
        end
    end

    assign err_underflow_o = err_q;

`ifdef SB_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] hazard_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            stall_q  <= '0;
            hazard_q <= '0;
        end else begin
            if (issue_valid_i && !ready_go_o && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (issue_valid_i && downstream_allowin_i && !ready_go_o &&
                (hazard_q != 32'hFFFF_FFFF)) begin
                hazard_q <= hazard_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o  = stall_q;
    assign hazard_cycles_o = hazard_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_scoreboard_bypass.sv
//==============================================================================
// Module   : tb_id_scoreboard_bypass
// Summary  : Table-driven bench for id_scoreboard_bypass with an expected-value
//            queue; rows are applied one per cycle and carry state forward.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_scoreboard_bypass;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int XLEN  = 32;
    localparam int NSRC  = 2;
    localparam int NFWD  = 3;
    localparam int CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 issue_valid, downstream_allowin, issue_we;
    logic [AW-1:0]        issue_dest;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC*AW-1:0]   src_addr;
    logic [NSRC*XLEN-1:0] rf_rdata;
    logic [NFWD-1:0]      fwd_valid, fwd_ready;
    logic [NFWD*AW-1:0]   fwd_dest;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 retire_valid;
    logic [AW-1:0]        retire_dest;
    logic                 flush;
    logic [NSRC*XLEN-1:0] src_value;
    logic                 ready_go, issue_fire, pending_any, err_underflow;
`ifdef SB_STATS_EN
    logic [31:0]          stall_cycles, hazard_cycles;
`endif

    always #5 clk = ~clk;

    id_scoreboard_bypass #(
        .NREG(NREG), .AW(AW), .XLEN(XLEN), .NSRC(NSRC), .NFWD(NFWD), .CNT_W(CNT_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .issue_valid_i        (issue_valid),
        .downstream_allowin_i (downstream_allowin),
        .issue_we_i           (issue_we),
        .issue_dest_i         (issue_dest),
        .src_valid_i          (src_valid),
        .src_addr_i           (src_addr),
        .rf_rdata_i           (rf_rdata),
        .fwd_valid_i          (fwd_valid),
        .fwd_dest_i           (fwd_dest),
        .fwd_ready_i          (fwd_ready),
        .fwd_data_i           (fwd_data),
        .retire_valid_i       (retire_valid),
        .retire_dest_i        (retire_dest),
        .flush_i              (flush),
        .src_value_o          (src_value),
        .ready_go_o           (ready_go),
        .issue_fire_o         (issue_fire),
        .pending_any_o        (pending_any),
        .err_underflow_o      (err_underflow)
`ifdef SB_STATS_EN
        ,
        .stall_cycles_o       (stall_cycles),
        .hazard_cycles_o      (hazard_cycles)
`endif
    );

    typedef struct {
        logic        iv, al, we;
        logic [4:0]  dst;
        logic [1:0]  sv;
        logic [4:0]  a0, a1;
        logic [2:0]  fv, fr;
        logic [4:0]  fd0, fd1, fd2;
        logic [31:0] d0, d1, d2;
        logic        rv;
        logic [4:0]  rd;
        logic        fl;
        logic        e_rg, e_fire, chk_v;
        logic [31:0] e_v0, e_v1;
        logic        e_pend, e_err, chk_stats;
    } vec_t;

    typedef struct {
        logic        rg, fire, chk_v;
        logic [31:0] v0, v1;
        logic        pend, err, chk_stats;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t idle();
        vec_t v;
        v.iv = 1'b0; v.al = 1'b1; v.we = 1'b0; v.dst = 5'd0;
        v.sv = 2'b00; v.a0 = 5'd1; v.a1 = 5'd2;
        v.fv = 3'b000; v.fr = 3'b000; v.fd0 = 5'd0; v.fd1 = 5'd0; v.fd2 = 5'd0;
        v.d0 = 32'd0; v.d1 = 32'd0; v.d2 = 32'd0;
        v.rv = 1'b0; v.rd = 5'd0; v.fl = 1'b0;
        v.e_rg = 1'b1; v.e_fire = 1'b0; v.chk_v = 1'b0;
        v.e_v0 = 32'd0; v.e_v1 = 32'd0;
        v.e_pend = 1'b0; v.e_err = 1'b0; v.chk_stats = 1'b0;
        return v;
    endfunction

    function automatic vec_t fire(input logic [4:0] d);
        vec_t v;
        v = idle();
        v.iv = 1'b1; v.we = 1'b1; v.dst = d; v.e_fire = 1'b1;
        return v;
    endfunction

    // Register-file read data is a known function of operand index and address.
    task automatic drive(input vec_t v);
        issue_valid        = v.iv;
        downstream_allowin = v.al;
        issue_we           = v.we;
        issue_dest         = v.dst;
        src_valid          = v.sv;
        src_addr           = {v.a1, v.a0};
        rf_rdata           = {32'h1000_0100 | {27'd0, v.a1}, 32'h1000_0000 | {27'd0, v.a0}};
        fwd_valid          = v.fv;
        fwd_ready          = v.fr;
        fwd_dest           = {v.fd2, v.fd1, v.fd0};
        fwd_data           = {v.d2, v.d1, v.d0};
        retire_valid       = v.rv;
        retire_dest        = v.rd;
        flush              = v.fl;
    endtask

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    task automatic check_out(input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL row%0d scoreboard: got empty queue, expected an entry", idx);
            return;
        end
        e = exp_q.pop_front();
        chk1($sformatf("row%0d ready_go", idx),      {31'd0, ready_go},      {31'd0, e.rg});
        chk1($sformatf("row%0d issue_fire", idx),    {31'd0, issue_fire},    {31'd0, e.fire});
        chk1($sformatf("row%0d pending_any", idx),   {31'd0, pending_any},   {31'd0, e.pend});
        chk1($sformatf("row%0d err_underflow", idx), {31'd0, err_underflow}, {31'd0, e.err});
        if (e.chk_v) begin
            chk1($sformatf("row%0d src_value0", idx), src_value[31:0],  e.v0);
            chk1($sformatf("row%0d src_value1", idx), src_value[63:32], e.v1);
        end
`ifdef SB_STATS_EN
        if (e.chk_stats) begin
            chk1($sformatf("row%0d stall_cycles", idx),  stall_cycles,  32'd0);
            chk1($sformatf("row%0d hazard_cycles", idx), hazard_cycles, 32'd0);
        end
`endif
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        e.rg = v.e_rg; e.fire = v.e_fire; e.chk_v = v.chk_v;
        e.v0 = v.e_v0; e.v1 = v.e_v1;
        e.pend = v.e_pend; e.err = v.e_err; e.chk_stats = v.chk_stats;
        exp_q.push_back(e);
        @(negedge clk);
        check_out(idx);
    endtask

    initial begin
        vec_t v;

        // Reset state
        v = idle(); v.chk_v = 1; v.e_v0 = 32'h1000_0001; v.e_v1 = 32'h1000_0102; vecs.push_back(v);
        // Writer to r5, then forwarded not-ready / ready
        v = fire(5); vecs.push_back(v);
        v = idle(); v.iv = 1; v.sv = 2'b01; v.a0 = 5; v.fv = 3'b001; v.fd0 = 5;
        v.e_rg = 0; v.e_pend = 1; vecs.push_back(v);
        v.fr = 3'b001; v.d0 = 32'h1234; v.e_rg = 1; v.e_fire = 1;
        v.chk_v = 1; v.e_v0 = 32'h1234; v.e_v1 = 32'h1000_0102; vecs.push_back(v);
        v = idle(); v.rv = 1; v.rd = 5; v.fv = 3'b100; v.fd2 = 5; v.fr = 3'b100; v.d2 = 32'h5;
        v.e_pend = 1; vecs.push_back(v);
        v = idle(); v.sv = 2'b01; v.a0 = 5; v.chk_v = 1; v.e_v0 = 32'h1000_0005;
        v.e_v1 = 32'h1000_0102; vecs.push_back(v);
        // Forward priority
        v = idle(); v.sv = 2'b11; v.a0 = 7; v.a1 = 7; v.fv = 3'b101; v.fd0 = 7; v.fd2 = 7;
        v.fr = 3'b101; v.d0 = 32'hA; v.d2 = 32'hB; v.chk_v = 1; v.e_v0 = 32'hA; v.e_v1 = 32'hA;
        vecs.push_back(v);
        v.fr = 3'b100; v.sv = 2'b01; v.chk_v = 0; v.e_rg = 0; vecs.push_back(v);
        v = idle(); v.sv = 2'b11; v.a0 = 7; v.a1 = 8; v.fv = 3'b011; v.fd0 = 8; v.fd1 = 7;
        v.fr = 3'b011; v.d0 = 32'hD; v.d1 = 32'hC; v.chk_v = 1; v.e_v0 = 32'hC; v.e_v1 = 32'hD;
        vecs.push_back(v);
        // Writer hidden from forward ports (divider)
        v = fire(9); vecs.push_back(v);
        v = idle(); v.sv = 2'b01; v.a0 = 9; v.e_rg = 0; v.e_pend = 1; vecs.push_back(v);
        v.sv = 2'b00; v.e_rg = 1; vecs.push_back(v);
        v = idle(); v.rv = 1; v.rd = 9; v.fv = 3'b100; v.fd2 = 9; v.fr = 3'b100; v.d2 = 32'h55;
        v.sv = 2'b01; v.a0 = 9; v.a1 = 0; v.chk_v = 1; v.e_v0 = 32'h55; v.e_v1 = 32'h0;
        v.e_pend = 1; vecs.push_back(v);
        v = idle(); v.sv = 2'b01; v.a0 = 9; v.chk_v = 1; v.e_v0 = 32'h1000_0009;
        v.e_v1 = 32'h1000_0102; vecs.push_back(v);
        // Counter saturation on r3
        v = fire(3); vecs.push_back(v);
        v.e_pend = 1; vecs.push_back(v);
        vecs.push_back(v);
        v.e_rg = 0; v.e_fire = 0; vecs.push_back(v);
        v = idle(); v.iv = 1; v.dst = 3; v.e_fire = 1; v.e_pend = 1; vecs.push_back(v);
        v = fire(4); v.al = 0; v.e_fire = 0; v.e_pend = 1; vecs.push_back(v);
        v = idle(); v.rv = 1; v.rd = 3; v.e_pend = 1; vecs.push_back(v);
        v = fire(3); v.rv = 1; v.rd = 3; v.e_pend = 1; vecs.push_back(v);
        v = fire(3); v.e_pend = 1; vecs.push_back(v);
        v.e_rg = 0; v.e_fire = 0; vecs.push_back(v);
        v = idle(); v.rv = 1; v.rd = 3; v.e_pend = 1; vecs.push_back(v);
        vecs.push_back(v);
        vecs.push_back(v);
        v = idle(); v.sv = 2'b01; v.a0 = 3; vecs.push_back(v);
        // Register zero and underflow
        v = idle(); v.sv = 2'b11; v.a0 = 0; v.a1 = 0; v.fv = 3'b001; v.fd0 = 0;
        v.d0 = 32'hFFFF; v.chk_v = 1; v.e_v0 = 32'h0; v.e_v1 = 32'h0; vecs.push_back(v);
        v = idle(); v.rv = 1; v.rd = 0; vecs.push_back(v);
        v = idle(); v.rv = 1; v.rd = 4; vecs.push_back(v);
        v = idle(); v.e_err = 1; vecs.push_back(v);
        // Flush with simultaneous fire
        v = fire(2); v.e_err = 1; vecs.push_back(v);
        v = fire(6); v.e_err = 1; v.e_pend = 1; vecs.push_back(v);
        vecs.push_back(v);
        v = fire(8); v.fl = 1; v.e_err = 1; v.e_pend = 1; vecs.push_back(v);
        v = idle(); v.sv = 2'b11; v.a0 = 8; v.a1 = 6; v.chk_v = 1; v.e_v0 = 32'h1000_0008;
        v.e_v1 = 32'h1000_0106; v.e_err = 1; v.chk_stats = 1; vecs.push_back(v);

        drive(idle());
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of an outstanding write discards all state.
        v = fire(10); v.e_err = 1; run_vec(v, 100);
        v = idle(); v.e_err = 1; v.e_pend = 1; run_vec(v, 101);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        v = idle(); v.sv = 2'b01; v.a0 = 10; v.chk_v = 1; v.e_v0 = 32'h1000_000A;
        v.e_v1 = 32'h1000_0102; v.chk_stats = 1; run_vec(v, 102);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_scoreboard_bypass.md
Name: id_scoreboard_bypass

Overview:
- Parametrised hazard and operand-bypass unit for the decode stage.
- Replaces fixed three-stage equality forwarding and the load-use-only stall with a per-register pending-write scoreboard plus NFWD priority forward ports.
- Forward ports carry a data-ready flag, so loads, multi-cycle mul/div and future long-latency units stall correctly.
- Sits between decode, the register file read ports and the EXE/MEM/WB result buses.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired zero
AW, 5, register address width (log2 NREG)
XLEN, 32, data width
NSRC, 2, source operands checked per instruction
NFWD, 3, forward ports; index 0 = youngest (EXE), NFWD-1 = oldest (WB)
CNT_W, 2, pending-counter width; max outstanding writes per register = 2^CNT_W-1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  decode holds a valid instruction
downstream_allowin  in  1  EXE can accept this cycle
issue_we  in  1  instruction writes a GPR
issue_dest  in  AW  destination register
src_valid  in  NSRC  operand i is read
src_addr  in  NSRC*AW  operand addresses, operand i at [i*AW +: AW]
rf_rdata  in  NSRC*XLEN  register-file read data per operand
fwd_valid  in  NFWD  forward port carries a GPR-writing instruction
fwd_dest  in  NFWD*AW  forward destination
fwd_ready  in  NFWD  forward data is final this cycle
fwd_data  in  NFWD*XLEN  forward data
retire_valid  in  1  a GPR write commits this cycle
retire_dest  in  AW  committed destination
flush  in  1  cancel all in-flight instructions
src_value  out  NSRC*XLEN  resolved operand values
ready_go  out  1  no hazard; decode may issue
issue_fire  out  1  issue_valid & ready_go & downstream_allowin
pending_any  out  1  any counter non-zero
err_underflow  out  1  sticky: retire to a register with count 0

Behaviour:
- State: cnt[1..NREG-1], each CNT_W bits. Register 0 has no counter. Reset: all cnt=0, err_underflow=0.
- Operand resolve is combinational, per source i with address a:
  - a==0 -> value 0, no hazard.
  - Otherwise take the lowest-index port j with fwd_valid[j] & fwd_dest[j]==a.
  - Match with fwd_ready[j]=1 -> value fwd_data[j], no hazard.
  - Match with fwd_ready[j]=0 -> hazard; value don't-care.
  - No match and cnt[a]!=0 -> hazard; writer is in a unit not exposed on a port.
  - No match and cnt[a]==0 -> value rf_rdata[i], no hazard.
- Hazard applies only when src_valid[i]=1.
- ready_go = no operand hazard AND NOT (issue_we & issue_dest!=0 & cnt[issue_dest]==max).
- ready_go is independent of issue_valid; issue_fire gates with issue_valid.
- Counter update at the clock edge:
  - inc = issue_fire & issue_we & issue_dest!=0 applied to issue_dest.
  - dec = retire_valid & retire_dest!=0 applied to retire_dest.
  - inc and dec on the same register -> unchanged. Different registers -> both applied.
- dec when cnt==0 -> counter stays 0 and err_underflow sets. err_underflow clears only on reset.
- Counters never wrap; saturation is prevented by the ready_go term above.
- flush=1 -> all cnt=0 next cycle; inc/dec in the same cycle are ignored. issue_fire is still driven combinationally; decode suppresses it.
- reset has priority over flush. Reset mid-stream discards all state.
- Latency: an issued writer blocks readers starting the next cycle, through its fwd port or its counter. Retire data appears on the oldest fwd port in the retire cycle, so there is no regfile write-read bubble.
- pending_any = OR of all counters, registered view. Used to drain before CSR/ertn.

Optional Feature:
- Macro: SB_STATS_EN.
- Defined: adds outputs stall_cycles (32) and hazard_cycles (32).
  - stall_cycles increments when issue_valid & !ready_go.
  - hazard_cycles increments when issue_valid & downstream_allowin & !ready_go.
  - Both counters saturate at 0xFFFFFFFF and clear on reset or flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Issue writer dest=5 (fire). Next cycle fwd0={valid,dest=5,ready=0} and reader src_addr0=5 -> ready_go=0. Next cycle fwd0 ready=1, data=0x1234 -> ready_go=1, src_value0=0x1234.
- fwd0 and fwd2 both dest=7, data 0xA / 0xB, both ready -> src_value=0xA (youngest wins).
- Issue dest=9 with no fwd port matching (divider busy), src_addr=9 -> stall. retire_valid dest=9 with fwd2 ready, data 0x55 -> ready_go=1, value 0x55; next cycle cnt[9]=0.
- Issue dest=3 with CNT_W=2 three times -> cnt=3; a 4th writer to r3 -> ready_go=0. Same-cycle fire plus retire of r3 at cnt=2 -> cnt stays 2.
- src_addr=0 with fwd0 dest=0 data 0xFFFF -> value 0, no stall. retire_dest=0 -> no counter change, no error. Retire r4 at cnt=0 -> err_underflow=1.
- Load cnt[2]=1 and cnt[6]=2, assert flush with a simultaneous fire to r8 -> all cnt=0, pending_any=0 next cycle. Under SB_STATS_EN, stats read 0.
